// File: rtl/conv_seq_pkg.sv
// Shared encodings for the raster-scan frame sequencer: FSM states, mode values
// and a width helper used to size the x/y/drain counters.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SCAN  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Processing-port bundle between the frame sequencer (master) and the
// mem_controller / kernel side that consumes its addresses and strobes (slave).
interface conv_frame_sequencer_if #(
    parameter int AW = 17
);
    logic          frame_ready;
    logic [1:0]    mode;
    logic [1:0]    kernel_sel;
    logic [AW-1:0] raddr_alu;
    logic [AW-1:0] waddr_alu;
    logic          wen_alu;
    logic          alu_bypass;
    logic [1:0]    kernel_sel_q;
    logic          pass_thru;
    logic          busy;
    logic          frame_done;

    modport master (
        input  frame_ready, mode, kernel_sel,
        output raddr_alu, waddr_alu, wen_alu, alu_bypass,
               kernel_sel_q, pass_thru, busy, frame_done
    );

    modport slave (
        output frame_ready, mode, kernel_sel,
        input  raddr_alu, waddr_alu, wen_alu, alu_bypass,
               kernel_sel_q, pass_thru, busy, frame_done
    );
endinterface

// File: rtl/conv_frame_sequencer_wb_delay_line.sv
// Write-back delay line: DEPTH-stage shift register, fully cleared by reset so
// an aborted frame leaves no write in flight.
module wb_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/conv_frame_sequencer.sv
// Raster-scan sequencer for the mem_controller processing port. Define
// BORDER_COPY_EN to write border pixels as raw copies instead of suppressing them.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int AW      = 17,
    parameter int KSIZE   = 3,
    parameter int ALU_LAT = 2
) (
    input logic                   CLK100MHZ,
    input logic                   rst_n,
    conv_frame_sequencer_if.master bus
);
    localparam int unsigned KR   = (KSIZE - 1) / 2;
    localparam int unsigned X_HI = IMG_W - KR;
    localparam int unsigned Y_HI = IMG_H - KR;
    localparam int XW  = clog2_min1(IMG_W);
    localparam int YW  = clog2_min1(IMG_H);
    localparam int DW  = clog2_min1(ALU_LAT);
    localparam int DLW = AW + 2;
    localparam logic [AW-1:0] ADDR_LAST  = AW'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ALU_LAT - 1);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [DW-1:0] drain_q;
    logic          pending_q;
    logic [1:0]    mode_q;
    logic [1:0]    kernel_q;
    logic          pass_thru_q;
    logic          busy_q;
    logic          done_q;

    logic           start_d;
    logic           mode_act;
    logic           pend_set;
    logic           border_d;
    logic [31:0]    x_ext;
    logic [31:0]    y_ext;
    logic [DLW-1:0] dl_d;
    logic [DLW-1:0] dl_q;

    assign mode_act = (bus.mode == MODE_SINGLE) || (bus.mode == MODE_CONT);
    assign pend_set = bus.frame_ready && (mode_q == MODE_CONT);

    // DONE restarts only for a continuous frame with a queued (or coincident) frame_ready.
    always_comb begin
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: start_d = bus.frame_ready && mode_act;
            ST_DONE: start_d = (mode_q == MODE_CONT) && (pending_q || bus.frame_ready) && mode_act;
            default: start_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            drain_q     <= '0;
            pending_q   <= 1'b0;
            mode_q      <= MODE_IDLE;
            kernel_q    <= 2'b00;
            pass_thru_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_d) begin
                state_q     <= ST_SCAN;
                mode_q      <= bus.mode;
                kernel_q    <= bus.kernel_sel;
                pass_thru_q <= 1'b0;
                busy_q      <= 1'b1;
                pending_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_IDLE;
                    ST_SCAN: begin
                        if (pend_set) pending_q <= 1'b1;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_DRAIN;
                            addr_q  <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                            drain_q <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + 1'b1;
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pend_set) pending_q <= 1'b1;
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        pass_thru_q <= 1'b1;
                        pending_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x_ext    = 32'(x_q);
    assign y_ext    = 32'(y_q);
    assign border_d = (x_ext < KR) || (x_ext >= X_HI) || (y_ext < KR) || (y_ext >= Y_HI);
    assign dl_d     = {state_q == ST_SCAN, addr_q, border_d};

    wb_delay_line #(.W(DLW), .DEPTH(ALU_LAT)) u_wb_delay (
        .clk   (CLK100MHZ),
        .rst_n (rst_n),
        .d_i   (dl_d),
        .q_o   (dl_q)
    );

    assign bus.raddr_alu    = addr_q;
    assign bus.waddr_alu    = dl_q[AW:1];
`ifdef BORDER_COPY_EN
    assign bus.wen_alu      = dl_q[DLW-1];
    assign bus.alu_bypass   = dl_q[DLW-1] & dl_q[0];
`else
    assign bus.wen_alu      = dl_q[DLW-1] & ~dl_q[0];
    assign bus.alu_bypass   = 1'b0;
`endif
    assign bus.kernel_sel_q = kernel_q;
    assign bus.pass_thru    = pass_thru_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer on an 8x4 image, 3x3 kernel, ALU_LAT=2.
module tb_conv_frame_sequencer;
    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int AW      = 5;
    localparam int KSIZE   = 3;
    localparam int ALU_LAT = 2;
    localparam int KR      = (KSIZE - 1) / 2;
    localparam int NPIX    = IMG_W * IMG_H;
`ifdef BORDER_COPY_EN
    localparam int EXP_WR  = 32;
    localparam int EXP_BYP = 20;
`else
    localparam int EXP_WR  = 12;
    localparam int EXP_BYP = 0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic          byp;
        int            cyc;
    } wr_t;

    typedef struct {
        logic          rst_n;
        logic          fr;
        logic [1:0]    mode;
        logic [1:0]    ksel;
        logic          busy;
        logic          pass;
        logic          wen;
        logic [AW-1:0] raddr;
        logic [1:0]    kq;
        logic          done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_wr = 0;
    int   n_byp = 0;
    wr_t  exp_q[$];
    wr_t  exp_e;
    vec_t tbl[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_frame_sequencer_if #(.AW(AW)) bus();

    conv_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .KSIZE(KSIZE), .ALU_LAT(ALU_LAT)
    ) dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic push_frame(input int start, input int lim);
        int x;
        int y;
        bit b;
        wr_t e;
        for (int a = 0; a < lim; a++) begin
            x = a % IMG_W;
            y = a / IMG_W;
            b = (x < KR) || (x >= IMG_W - KR) || (y < KR) || (y >= IMG_H - KR);
            e.addr = AW'(a);
            e.cyc  = start + a + ALU_LAT;
`ifdef BORDER_COPY_EN
            e.byp = b;
            exp_q.push_back(e);
`else
            e.byp = 1'b0;
            if (!b) exp_q.push_back(e);
`endif
        end
    endtask

    // Pulse frame_ready for one edge; raddr 0 appears in the cycle after that edge.
    task automatic pulse_fr(input int lim, output int start);
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b1;
        start = cyc + 1;
        push_frame(start, lim);
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.wen_alu === 1'b1) begin
            n_wr++;
            if (bus.alu_bypass === 1'b1) n_byp++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: write to %0d at cycle %0d, none expected",
                         bus.waddr_alu, cyc);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.waddr_alu), 32'(exp_e.addr));
                chk("wr_bypass", 32'(bus.alu_bypass), 32'(exp_e.byp));
                chk("wr_cycle", 32'(cyc), 32'(exp_e.cyc));
            end
        end
    end

    initial begin
        int s;
        int dn;
        int dcyc;
        int dcy[2];
        int nbusy;

        bus.frame_ready = 1'b0;
        bus.mode        = 2'b00;
        bus.kernel_sel  = 2'b00;

        // rst_n fr mode ksel | busy pass wen raddr kq done
        tbl[0] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst_n           = tbl[i].rst_n;
            bus.frame_ready = tbl[i].fr;
            bus.mode        = tbl[i].mode;
            bus.kernel_sel  = tbl[i].ksel;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
            chk("tbl_pass_thru", 32'(bus.pass_thru), 32'(tbl[i].pass));
            chk("tbl_wen", 32'(bus.wen_alu), 32'(tbl[i].wen));
            chk("tbl_raddr", 32'(bus.raddr_alu), 32'(tbl[i].raddr));
            chk("tbl_kernel_q", 32'(bus.kernel_sel_q), 32'(tbl[i].kq));
            chk("tbl_frame_done", 32'(bus.frame_done), 32'(tbl[i].done));
        end
        bus.frame_ready = 1'b0;

        // Single-shot frame; kernel_sel changes and a stray frame_ready mid-scan.
        bus.mode       = 2'b01;
        bus.kernel_sel = 2'b01;
        n_wr  = 0;
        n_byp = 0;
        pulse_fr(NPIX, s);
        for (int a = 0; a < NPIX; a++) begin
            @(negedge clk);
            chk("scan_raddr", 32'(bus.raddr_alu), 32'(a));
            chk("scan_busy", 32'(bus.busy), 32'd1);
            chk("scan_kernel_q", 32'(bus.kernel_sel_q), 32'd1);
            if (a == 0) chk("scan_pass_thru", 32'(bus.pass_thru), 32'd0);
            if (a == 10) bus.kernel_sel = 2'b10;
            if (a == 20) bus.frame_ready = 1'b1;
            if (a == 21) bus.frame_ready = 1'b0;
        end
        dn   = 0;
        dcyc = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                dn++;
                dcyc = cyc;
            end
        end
        chk("single_done_pulses", 32'(dn), 32'd1);
        chk("single_done_cycle", 32'(dcyc), 32'(s + NPIX + ALU_LAT));
        chk("single_end_busy", 32'(bus.busy), 32'd0);
        chk("single_end_pass_thru", 32'(bus.pass_thru), 32'd1);
        chk("single_end_kernel_q", 32'(bus.kernel_sel_q), 32'd1);
        chk("single_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("single_write_count", 32'(n_wr), 32'(EXP_WR));
        chk("single_bypass_count", 32'(n_byp), 32'(EXP_BYP));

        // Continuous mode with two pulses during the first scan.
        bus.mode = 2'b10;
        n_wr  = 0;
        n_byp = 0;
        dn    = 0;
        dcy[0] = -1;
        dcy[1] = -1;
        pulse_fr(NPIX, s);
        for (int i = 0; i < 76; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                if (dn < 2) dcy[dn] = cyc;
                dn++;
            end
            if (i == 0) chk("cont_kernel_q_new", 32'(bus.kernel_sel_q), 32'd2);
            if (i == 5) push_frame(s + NPIX + ALU_LAT + 1, NPIX);
            if (i == 5 || i == 15) bus.frame_ready = 1'b1;
            if (i == 6 || i == 16) bus.frame_ready = 1'b0;
            if (i == 10) chk("cont_pass_thru", 32'(bus.pass_thru), 32'd0);
            if (i == NPIX + ALU_LAT) chk("cont_done_busy", 32'(bus.busy), 32'd0);
            if (i == NPIX + ALU_LAT + 1) begin
                chk("cont_restart_busy", 32'(bus.busy), 32'd1);
                chk("cont_restart_raddr", 32'(bus.raddr_alu), 32'd0);
            end
            if (i == 2 * NPIX + ALU_LAT) chk("cont_second_last_raddr", 32'(bus.raddr_alu), 32'(NPIX - 1));
        end
        chk("cont_done_pulses", 32'(dn), 32'd2);
        chk("cont_done1_cycle", 32'(dcy[0]), 32'(s + NPIX + ALU_LAT));
        chk("cont_done2_cycle", 32'(dcy[1]), 32'(s + 2 * NPIX + 2 * ALU_LAT + 1));
        chk("cont_end_busy", 32'(bus.busy), 32'd0);
        chk("cont_end_pass_thru", 32'(bus.pass_thru), 32'd1);
        chk("cont_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("cont_write_count", 32'(n_wr), 32'(2 * EXP_WR));
        chk("cont_bypass_count", 32'(n_byp), 32'(2 * EXP_BYP));

        // Reset pulse while raddr_alu is 13 aborts the frame.
        bus.mode = 2'b01;
        pulse_fr(12, s);
        for (int a = 0; a <= 13; a++) @(negedge clk);
        chk("abort_raddr_before", 32'(bus.raddr_alu), 32'd13);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_wen", 32'(bus.wen_alu), 32'd0);
        chk("abort_raddr", 32'(bus.raddr_alu), 32'd0);
        chk("abort_pass_thru", 32'(bus.pass_thru), 32'd1);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) nbusy++;
        end
        chk("abort_stays_idle", 32'(nbusy), 32'd0);
        chk("abort_pending_writes", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
